// File: rtl/score_display_if.sv
// Request and display bundle between the score sources and the score display sequencer.
// The master drives the score/best updates and game_over level.
// The slave (the sequencer) drives busy and the display-driver inputs.
interface score_display_if #(
  parameter int unsigned BIN_W = 14
);

  logic [BIN_W-1:0] score_bin;
  logic             score_vld;
  logic [BIN_W-1:0] best_bin;
  logic             best_vld;
  logic             game_over;
  logic             busy;
  logic [15:0]      hexs;
  logic [3:0]       points;
  logic [3:0]       LEs;

  modport master (
    output score_bin, score_vld, best_bin, best_vld, game_over,
    input  busy, hexs, points, LEs
  );

  modport slave (
    input  score_bin, score_vld, best_bin, best_vld, game_over,
    output busy, hexs, points, LEs
  );

endinterface

// File: rtl/score_display_ctrl.sv
// Score display sequencer: converts current/best binary scores to 4-digit BCD one bit per
// cycle (shift-add-3) and drives the 7-segment display driver, alternating between the two
// views while game_over is high.
// Optional build macro LZB_EN enables leading-zero blanking on LEs.
module score_display_ctrl #(
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned ALT_PERIOD = 50000000
) (
  input logic            clk,
  input logic            rst,
  score_display_if.slave bus_io
);

  localparam int unsigned CntW = (ALT_PERIOD > 2) ? $clog2(ALT_PERIOD) : 1;
  localparam int unsigned ShW  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e           state_q;
  logic [BIN_W-1:0] pend_score_q, pend_best_q;
  logic             pend_s_q, pend_b_q;
  logic             src_best_q;
  logic [BIN_W-1:0] sr_q;
  logic [15:0]      acc_q;
  logic [ShW-1:0]   shift_cnt_q;
  logic [15:0]      score_bcd_q, best_bcd_q;

  logic             view_q, view_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [15:0]      hexs_q, hexs_d;
  logic [3:0]       points_q, points_d;
  logic [3:0]       les_q, les_d;
  logic [15:0]      score_nxt, best_nxt;
  logic [15:0]      acc_adj;

  // Values above four decimal digits saturate at 9999.
  function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
    if (32'(v) > 32'd9999) begin
      return BIN_W'(9999);
    end
    return v;
  endfunction

  // Shift-add-3 correction: any BCD nibble >= 5 gets +3 before the next shift.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign acc_adj = add3(acc_q);

  // Request capture plus conversion FSM; a strobe on the accept edge is consumed directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pend_score_q <= '0;
      pend_best_q  <= '0;
      pend_s_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      src_best_q   <= 1'b0;
      sr_q         <= '0;
      acc_q        <= '0;
      shift_cnt_q  <= '0;
      score_bcd_q  <= '0;
      best_bcd_q   <= '0;
    end else begin
      if (bus_io.score_vld) begin
        pend_score_q <= bus_io.score_bin;
        pend_s_q     <= 1'b1;
      end
      if (bus_io.best_vld) begin
        pend_best_q <= bus_io.best_bin;
        pend_b_q    <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus_io.score_vld || pend_s_q) begin
            sr_q        <= clamp(bus_io.score_vld ? bus_io.score_bin : pend_score_q);
            acc_q       <= '0;
            shift_cnt_q <= '0;
            pend_s_q    <= 1'b0;
            src_best_q  <= 1'b0;
            state_q     <= StConv;
          end else if (bus_io.best_vld || pend_b_q) begin
            sr_q        <= clamp(bus_io.best_vld ? bus_io.best_bin : pend_best_q);
            acc_q       <= '0;
            shift_cnt_q <= '0;
            pend_b_q    <= 1'b0;
            src_best_q  <= 1'b1;
            state_q     <= StConv;
          end
        end
        StConv: begin
          acc_q       <= {acc_adj[14:0], sr_q[BIN_W-1]};
          sr_q        <= sr_q << 1;
          shift_cnt_q <= shift_cnt_q + ShW'(1);
          if (shift_cnt_q == ShW'(BIN_W - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (src_best_q) begin
            best_bcd_q <= acc_q;
          end else begin
            score_bcd_q <= acc_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // View alternation and display outputs; uses the value being committed this edge so a new
  // result reaches hexs without an extra cycle.
  always_comb begin
    cnt_d  = cnt_q;
    view_d = view_q;
    if (!bus_io.game_over) begin
      cnt_d  = '0;
      view_d = 1'b0;
    end else if (cnt_q == CntW'(ALT_PERIOD - 1)) begin
      cnt_d  = '0;
      view_d = ~view_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    score_nxt = (state_q == StDone && !src_best_q) ? acc_q : score_bcd_q;
    best_nxt  = (state_q == StDone && src_best_q) ? acc_q : best_bcd_q;
    hexs_d    = view_d ? best_nxt : score_nxt;
    points_d  = view_d ? 4'b0001 : 4'b0000;
`ifdef LZB_EN
    les_d[3] = (hexs_d[15:12] == 4'd0);
    les_d[2] = (hexs_d[15:8] == 8'd0);
    les_d[1] = (hexs_d[15:4] == 12'd0);
    les_d[0] = 1'b0;
`else
    les_d = 4'b0000;
`endif
  end

  // Output and view registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      view_q   <= 1'b0;
      cnt_q    <= '0;
      hexs_q   <= 16'h0000;
      points_q <= 4'b0000;
`ifdef LZB_EN
      les_q    <= 4'b1110;
`else
      les_q    <= 4'b0000;
`endif
    end else begin
      view_q   <= view_d;
      cnt_q    <= cnt_d;
      hexs_q   <= hexs_d;
      points_q <= points_d;
      les_q    <= les_d;
    end
  end

  assign bus_io.busy   = (state_q != StIdle);
  assign bus_io.hexs   = hexs_q;
  assign bus_io.points = points_q;
  assign bus_io.LEs    = les_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed scenarios plus random score/best updates, checked by
// a scoreboard against a decimal reference model (pending latest-wins, score priority).
module tb_score_display_ctrl;

  localparam int unsigned BinW       = 14;
  localparam int unsigned AltPeriod  = 8;
  localparam int unsigned ConvCycles = BinW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_display_if #(.BIN_W(BinW)) bus_if ();

  score_display_ctrl #(
    .BIN_W     (BinW),
    .ALT_PERIOD(AltPeriod)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_best;
    int unsigned val;
  } job_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_commit = 0;

  // Reference model state
  bit          m_pend_s, m_pend_b;
  int unsigned m_pend_sv, m_pend_bv;
  int unsigned m_score, m_best;
  job_t        exp_q[$];

  bit          chk_due;
  bit          prev_busy;
  int unsigned busy_len;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [3:0] exp_les(input int unsigned v);
`ifdef LZB_EN
    int unsigned c;
    c = (v > 9999) ? 9999 : v;
    return {c < 1000, c < 100, c < 10, 1'b0};
`else
    return 4'(v & 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: detects accepts (busy rise) and commits (busy fall), pops the scoreboard.
  initial begin
    job_t j;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        busy_len  = 0;
        chk_due   = 1'b0;
      end else begin
        if (chk_due) begin
          chk("commit_hexs", 32'(bus_if.hexs), 32'(to_bcd(m_score)));
          chk("commit_points", 32'(bus_if.points), 32'd0);
          chk("commit_les", 32'(bus_if.LEs), 32'(exp_les(m_score)));
          chk_due = 1'b0;
        end
        if (bus_if.busy && !prev_busy) begin
          chk("accept_has_pending", 32'(m_pend_s || m_pend_b), 32'd1);
          if (m_pend_s) begin
            j.is_best = 1'b0;
            j.val     = m_pend_sv;
            m_pend_s  = 1'b0;
            exp_q.push_back(j);
          end else if (m_pend_b) begin
            j.is_best = 1'b1;
            j.val     = m_pend_bv;
            m_pend_b  = 1'b0;
            exp_q.push_back(j);
          end
          busy_len = 1;
        end else if (bus_if.busy) begin
          busy_len++;
        end
        if (!bus_if.busy && prev_busy) begin
          n_commit++;
          chk("busy_len", busy_len, ConvCycles);
          chk("commit_has_job", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            j = exp_q.pop_front();
            if (j.is_best) m_best = j.val;
            else m_score = j.val;
            chk_due = 1'b1;
          end
        end
        prev_busy = bus_if.busy;
      end
    end
  end

  // Drive strobes just after a posedge; the model sees them at the sampling edge.
  task automatic strobe(input bit do_s, input int unsigned sv, input bit do_b,
                        input int unsigned bv);
    bus_if.score_vld = do_s;
    bus_if.score_bin = BinW'(sv);
    bus_if.best_vld  = do_b;
    bus_if.best_bin  = BinW'(bv);
    @(posedge clk);
    if (do_s) begin
      m_pend_s  = 1'b1;
      m_pend_sv = sv;
    end
    if (do_b) begin
      m_pend_b  = 1'b1;
      m_pend_bv = bv;
    end
    #1;
    bus_if.score_vld = 1'b0;
    bus_if.best_vld  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned k;
    bit          busy_work;
    k = 0;
    busy_work = 1'b1;
    while (busy_work && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      busy_work = (exp_q.size() != 0) || m_pend_s || m_pend_b || bus_if.busy || chk_due;
    end
    chk("drain_in_time", 32'(busy_work), 32'd0);
  endtask

  // Assert reset between edges and check outputs before the next clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_hexs", 32'(bus_if.hexs), 32'h0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_points", 32'(bus_if.points), 32'd0);
    chk("rst_les", 32'(bus_if.LEs), 32'(exp_les(0)));
    m_pend_s = 1'b0;
    m_pend_b = 1'b0;
    m_score  = 0;
    m_best   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Raise game_over for ncyc edges; view toggles each time the 0..AltPeriod-1 count wraps.
  task automatic game_over_check(input int unsigned ncyc);
    bit vb;
    bus_if.game_over = 1'b1;
    for (int k = 0; k < int'(ncyc); k++) begin
      @(posedge clk);
      @(negedge clk);
      vb = (((k + 1) / int'(AltPeriod)) % 2) == 1;
      chk("alt_hexs", 32'(bus_if.hexs), 32'(vb ? to_bcd(m_best) : to_bcd(m_score)));
      chk("alt_points", 32'(bus_if.points), vb ? 32'd1 : 32'd0);
      chk("alt_les", 32'(bus_if.LEs), 32'(vb ? exp_les(m_best) : exp_les(m_score)));
    end
    @(posedge clk);
    #1;
    bus_if.game_over = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("go_drop_hexs", 32'(bus_if.hexs), 32'(to_bcd(m_score)));
    chk("go_drop_points", 32'(bus_if.points), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 9);
      1:       return $urandom_range(0, 999);
      2:       return $urandom_range(0, 9999);
      default: return $urandom_range(10000, 16383);
    endcase
  endfunction

  initial begin
    int unsigned c0;
    int unsigned c1;
    int unsigned k;
    bus_if.score_vld = 1'b0;
    bus_if.best_vld  = 1'b0;
    bus_if.score_bin = '0;
    bus_if.best_bin  = '0;
    bus_if.game_over = 1'b0;
    m_pend_s = 1'b0;
    m_pend_b = 1'b0;
    m_score  = 0;
    m_best   = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("init_hexs", 32'(bus_if.hexs), 32'h0);
    chk("init_busy", 32'(bus_if.busy), 32'd0);
    chk("init_les", 32'(bus_if.LEs), 32'(exp_les(0)));
    rst = 1'b0;
    idle(2);

    strobe(1'b1, 1234, 1'b0, 0);
    wait_drain(60);
    async_reset();
    idle(2);

    strobe(1'b1, 42, 1'b0, 0);
    wait_drain(60);
    strobe(1'b1, 12000, 1'b0, 0);
    wait_drain(60);
    strobe(1'b1, 0, 1'b0, 0);
    wait_drain(60);

    strobe(1'b1, 7, 1'b1, 500);
    wait_drain(80);
    game_over_check(40);

    // Latest pending value wins; reset during the second conversion discards it.
    c0 = n_commit;
    strobe(1'b1, 100, 1'b0, 0);
    idle(3);
    strobe(1'b1, 200, 1'b0, 0);
    idle(2);
    strobe(1'b1, 300, 1'b0, 0);
    k = 0;
    while (!(n_commit == c0 + 1 && bus_if.busy) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("second_conv_started", 32'(n_commit == c0 + 1 && bus_if.busy), 32'd1);
    idle(4);
    async_reset();
    c1 = n_commit;
    idle(40);
    chk("no_commit_after_rst", n_commit, c1);
    chk("hexs_after_rst", 32'(bus_if.hexs), 32'h0);
    chk("busy_after_rst", 32'(bus_if.busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    strobe(1'b1, rand_val(), 1'b0, 0);
        2:       strobe(1'b0, 0, 1'b1, rand_val());
        3:       strobe(1'b1, rand_val(), 1'b1, rand_val());
        default: idle($urandom_range(1, 20));
      endcase
    end
    wait_drain(200);
    game_over_check(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual not finished required finished by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
